// File: rtl/rx_path_pkg.sv
// Shared RX-path definitions: ring geometry, pointer widths, trigger FSM
// encoding and default sizing of the TLP trigger block.
package rx_path_pkg;

  localparam int RING_DEPTH = 512;
  localparam int PTR_W      = 10;                      // ring index + wrap bit
  localparam int AVAIL_W    = $clog2(RING_DEPTH) + 1;  // 0..512 inclusive
  localparam int QW_W       = 9;

  localparam int DEF_MAX_TLP_QWORDS = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int DEF_PAGE_QWORDS    = 262144;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ_TLP     = 2'd1,
    REQ_CHG     = 2'd2,
    WAIT_COMMIT = 2'd3
  } trig_state_e;

endpackage

// File: rtl/rx_ptr_diff.sv
// Registered fill level of the RX ring from the extended wr/rd pointers.
// Deliberately not reset: it tracks the pointers even while the trigger FSM
// is held in reset, so a valid fill level exists on the first released cycle.
module rx_ptr_diff
  import rx_path_pkg::*;
(
  input  logic               clk_i,
  input  logic [PTR_W-1:0]   wr_ptr_i,
  input  logic [PTR_W-1:0]   rd_ptr_i,
  output logic [AVAIL_W-1:0] avail_o
);

  logic [AVAIL_W-1:0] avail_q;

  // mod-1024 difference; the wrap bit keeps a full ring (512) distinct from empty
  always_ff @(posedge clk_i) begin
    avail_q <= AVAIL_W'(wr_ptr_i - rd_ptr_i);
  end

  assign avail_o = avail_q;

endmodule

// File: rtl/rx_tlp_trigger.sv
// Decides when the PCIe TX side should push ring data into the host huge
// page: full TLPs when enough data is present, a short TLP after an idle
// timeout, and a page change (with its final TLP) when the page is nearly full.
module rx_tlp_trigger
  import rx_path_pkg::*;
#(
  parameter int MAX_TLP_QWORDS = DEF_MAX_TLP_QWORDS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PAGE_QWORDS    = DEF_PAGE_QWORDS
) (
  input  logic             trn_clk,
  input  logic             trn_reset_n,
  input  logic [PTR_W-1:0] commited_wr_address,
  input  logic [PTR_W-1:0] commited_rd_address,
  output logic             trigger_tlp,
  input  logic             trigger_tlp_ack,
  output logic             change_huge_page,
  input  logic             change_huge_page_ack,
  output logic             send_last_tlp_change_huge_page,
  output logic [QW_W-1:0]  qwords_to_send
);

  localparam int PU_W  = $clog2(PAGE_QWORDS);
  localparam int PR_W  = PU_W + 1;
  localparam int CMP_W = (PR_W > AVAIL_W) ? PR_W : AVAIL_W;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CMP_W-1:0] PAGE_C = CMP_W'(PAGE_QWORDS);
  localparam logic [CMP_W-1:0] MAX_C  = CMP_W'(MAX_TLP_QWORDS);
  localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT_CYCLES - 1);

  trig_state_e        state_q, state_d;
  logic [QW_W-1:0]    qw_q, qw_d;
  logic [PTR_W-1:0]   rd_base_q, rd_base_d;
  logic [PU_W-1:0]    pu_q, pu_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [AVAIL_W-1:0] avail;
  logic [CMP_W-1:0]   avail_c, rem_c, min_c;

  rx_ptr_diff u_ptr_diff (
    .clk_i    (trn_clk),
    .wr_ptr_i (commited_wr_address),
    .rd_ptr_i (commited_rd_address),
    .avail_o  (avail)
  );

  // page_used never reaches PAGE_QWORDS, so the remainder is always >= 1
  always_comb begin
    avail_c = CMP_W'(avail);
    rem_c   = PAGE_C - CMP_W'(pu_q);
    min_c   = (avail_c < rem_c) ? avail_c : rem_c;
  end

  // next-state: request selection in IDLE, handshakes, commit tracking
  always_comb begin
    state_d   = state_q;
    qw_d      = qw_q;
    rd_base_d = rd_base_q;
    pu_d      = pu_q;
    cnt_d     = '0;
    case (state_q)
      IDLE: begin
        if (rem_c <= MAX_C && avail_c != '0) begin
          state_d   = REQ_CHG;
          qw_d      = QW_W'(min_c);
          rd_base_d = commited_rd_address;
        end else if (avail_c >= MAX_C) begin
          state_d   = REQ_TLP;
          qw_d      = QW_W'(MAX_TLP_QWORDS);
          rd_base_d = commited_rd_address;
        end else if (avail_c != '0) begin
          if (cnt_q == TMO_C) begin
            state_d   = REQ_TLP;
            qw_d      = QW_W'(avail_c);
            rd_base_d = commited_rd_address;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      REQ_TLP: begin
        if (trigger_tlp_ack) begin
          pu_d    = pu_q + PU_W'(qw_q);
          state_d = WAIT_COMMIT;
        end
      end
      REQ_CHG: begin
        if (change_huge_page_ack) begin
          pu_d    = '0;
          state_d = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        if (commited_rd_address == rd_base_q + PTR_W'(qw_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers; reset drops any request and its length
  always_ff @(posedge trn_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state_q   <= IDLE;
      qw_q      <= '0;
      rd_base_q <= '0;
      pu_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      qw_q      <= qw_d;
      rd_base_q <= rd_base_d;
      pu_q      <= pu_d;
      cnt_q     <= cnt_d;
    end
  end

  assign trigger_tlp                    = (state_q == REQ_TLP);
  assign change_huge_page               = (state_q == REQ_CHG);
  assign send_last_tlp_change_huge_page = (state_q == REQ_CHG);
  assign qwords_to_send                 = qw_q;

endmodule
